// File: rtl/lsu_controller_pkg.sv
// Shared definitions for the load/store unit: memory op codes, the default
// bus timeout, and a small op decoder used by both the controller and the lane aligner.
package lsu_controller_pkg;

   localparam logic [5:0] LB  = 6'h20;
   localparam logic [5:0] LH  = 6'h21;
   localparam logic [5:0] LW  = 6'h23;
   localparam logic [5:0] LBU = 6'h24;
   localparam logic [5:0] LHU = 6'h25;
   localparam logic [5:0] SB  = 6'h28;
   localparam logic [5:0] SH  = 6'h29;
   localparam logic [5:0] SW  = 6'h2B;

   // System-level default; override through the TIMEOUT parameter.
   localparam int LSU_TIMEOUT_DEFAULT = 255;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2,
      SZ_NONE = 2'd3
   } access_size_e;

   typedef struct packed {
      logic         store;
      logic         sign;
      access_size_e size;
   } op_info_t;

   // SZ_NONE marks any code outside the eight legal memory ops.
   function automatic op_info_t decode_op(input logic [5:0] op);
      op_info_t info;
      info = '{store: 1'b0, sign: 1'b0, size: SZ_NONE};
      case (op)
         LB:  info = '{store: 1'b0, sign: 1'b1, size: SZ_BYTE};
         LBU: info = '{store: 1'b0, sign: 1'b0, size: SZ_BYTE};
         LH:  info = '{store: 1'b0, sign: 1'b1, size: SZ_HALF};
         LHU: info = '{store: 1'b0, sign: 1'b0, size: SZ_HALF};
         LW:  info = '{store: 1'b0, sign: 1'b0, size: SZ_WORD};
         SB:  info = '{store: 1'b1, sign: 1'b0, size: SZ_BYTE};
         SH:  info = '{store: 1'b1, sign: 1'b0, size: SZ_HALF};
         SW:  info = '{store: 1'b1, sign: 1'b0, size: SZ_WORD};
         default: ;
      endcase
      return info;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store strobes and replicated data,
// load extraction with sign/zero extension, and the alignment check.
module lsu_lane_align
   import lsu_controller_pkg::*;
(
   input  logic [5:0]  op,
   input  logic [1:0]  offset,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  strb,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata_ext,
   output logic        misalign
);

   op_info_t    info;
   logic [7:0]  rbyte;
   logic [15:0] rhalf;

   assign info  = decode_op(op);
   assign rbyte = rdata[{offset, 3'b000} +: 8];
   // Odd half offsets are rejected as misaligned, so only the upper bit picks the half.
   assign rhalf = offset[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      strb      = 4'b0000;
      wdata_rep = 32'h0;
      rdata_ext = 32'h0;
      misalign  = 1'b0;
      case (info.size)
         SZ_BYTE: begin
            if (info.store) begin
               strb      = 4'b0001 << offset;
               wdata_rep = {4{wdata[7:0]}};
            end
            rdata_ext = {{24{info.sign & rbyte[7]}}, rbyte};
         end
         SZ_HALF: begin
            misalign = offset[0];
            if (info.store) begin
               strb      = 4'b0011 << offset;
               wdata_rep = {2{wdata[15:0]}};
            end
            rdata_ext = {{16{info.sign & rhalf[15]}}, rhalf};
         end
         SZ_WORD: begin
            misalign = |offset;
            if (info.store) begin
               strb      = 4'hF;
               wdata_rep = wdata;
            end
            rdata_ext = rdata;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/lsu_controller.sv
// Load/store controller: accepts one op at a time, checks alignment, runs a
// registered req/ack bus access with timeout, and returns a one-cycle response.
module lsu_controller
   import lsu_controller_pkg::*;
#(
   parameter int TIMEOUT = LSU_TIMEOUT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [5:0]  ALUControl,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUS  = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

   logic [1:0]  state_reg;
   logic [5:0]  op_reg;
   logic [1:0]  offset_reg;
   logic [31:0] cnt_reg;

   logic        idle;
   logic [5:0]  sel_op;
   logic [1:0]  sel_offset;
   logic [3:0]  align_strb;
   logic [31:0] align_wdata;
   logic [31:0] align_rdata;
   logic        align_misalign;
   logic        illegal_op;
   logic        timeout_hit;

   assign idle       = (state_reg == ST_IDLE);
   assign req_ready  = idle;
   assign stall      = req_valid && !rsp_valid;
   assign illegal_op = (decode_op(ALUControl).size == SZ_NONE);
   assign timeout_hit = (TIMEOUT != 0) && (cnt_reg == TIMEOUT_LAST);

   // In IDLE the aligner looks at the incoming request so bus outputs can be
   // registered on the acceptance edge; afterwards it uses the latched op.
   assign sel_op     = idle ? ALUControl : op_reg;
   assign sel_offset = idle ? addr[1:0]  : offset_reg;

   lsu_lane_align u_align (
      .op        (sel_op),
      .offset    (sel_offset),
      .wdata     (wdata),
      .rdata     (mem_rdata),
      .strb      (align_strb),
      .wdata_rep (align_wdata),
      .rdata_ext (align_rdata),
      .misalign  (align_misalign)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= ST_IDLE;
         op_reg     <= 6'h0;
         offset_reg <= 2'b00;
         cnt_reg    <= 32'h0;
         rsp_valid  <= 1'b0;
         rsp_err    <= 1'b0;
         rsp_rdata  <= 32'h0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= 32'h0;
         mem_wstrb  <= 4'b0000;
         mem_wdata  <= 32'h0;
      end else begin
         // Response fields are pulses: only the transition into RESP sets them.
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= 32'h0;
         case (state_reg)
            ST_IDLE: begin
               if (req_valid) begin
                  op_reg     <= ALUControl;
                  offset_reg <= addr[1:0];
                  cnt_reg    <= 32'h0;
                  if (illegal_op || align_misalign) begin
                     state_reg <= ST_RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                  end else begin
                     state_reg <= ST_BUS;
                     mem_req   <= 1'b1;
                     mem_we    <= decode_op(ALUControl).store;
                     mem_addr  <= {addr[31:2], 2'b00};
                     mem_wstrb <= align_strb;
                     mem_wdata <= align_wdata;
                  end
               end
            end
            ST_BUS: begin
               if (mem_ack || timeout_hit) begin
                  state_reg <= ST_RESP;
                  rsp_valid <= 1'b1;
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  mem_wstrb <= 4'b0000;
                  mem_wdata <= 32'h0;
                  // An ack in the expiring cycle still completes normally.
                  if (mem_ack) begin
                     rsp_rdata <= mem_we ? 32'h0 : align_rdata;
                  end else begin
                     rsp_err <= 1'b1;
                  end
               end else begin
                  cnt_reg <= cnt_reg + 32'h1;
               end
            end
            ST_RESP: begin
               state_reg <= ST_IDLE;
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_controller.sv
// Randomized self-checking bench for lsu_controller with a behavioural
// memory/reference model and the directed scenarios from the test plan.
module tb_lsu_controller;
   import lsu_controller_pkg::*;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [5:0]  ALUControl = 6'h0;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        stall;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = 32'h0;

   logic [31:0] mem_env [0:255];
   logic [31:0] ref_mem [0:255];

   int n_checks = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   lsu_controller #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .ALUControl(ALUControl), .addr(addr), .wdata(wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .stall(stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic int op_bytes(input logic [5:0] op);
      if (op == LB || op == LBU || op == SB) return 1;
      if (op == LH || op == LHU || op == SH) return 2;
      if (op == LW || op == SW) return 4;
      return 0;
   endfunction

   function automatic bit op_store(input logic [5:0] op);
      return (op == SB || op == SH || op == SW);
   endfunction

   function automatic logic [31:0] load_value(input logic [5:0] op, input logic [31:0] word, input int o);
      logic [31:0] sh;
      logic [31:0] v;
      sh = word >> (8 * o);
      v = 32'h0;
      if (op == LB || op == LBU) begin
         v = sh & 32'hFF;
         if (op == LB && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end else if (op == LH || op == LHU) begin
         v = sh & 32'hFFFF;
         if (op == LH && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end else if (op == LW) begin
         v = word;
      end
      return v;
   endfunction

   // Issue one op, act as the memory (ack after 'waits' bus cycles unless no_ack),
   // and compare every observable against the reference model.
   task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] wd, input int waits, input bit no_ack,
                         output logic [31:0] got_rdata, output logic got_err);
      int nb, o, exp_cycle, exp_reqs, got_cycle, reqs;
      bit illegal, mis, early, tmo, st, exp_err, stall_ok, ready_ok, stable_ok, done;
      logic [3:0]  exp_strb, got_strb;
      logic [31:0] exp_wd, got_wd, exp_addr, got_addr, exp_rdata;
      logic        got_we;
      logic [7:0]  idx, eidx;

      nb = op_bytes(op);
      o = int'(a[1:0]);
      st = op_store(op);
      illegal = (nb == 0);
      mis = (nb == 2 && (o % 2) != 0) || (nb == 4 && o != 0);
      early = illegal || mis;
      tmo = !early && (no_ack || waits >= TO);
      exp_err = early || tmo;
      exp_cycle = early ? 1 : (tmo ? TO + 1 : 2 + waits);
      exp_reqs = early ? 0 : (tmo ? TO : waits + 1);
      exp_addr = a & 32'hFFFF_FFFC;
      exp_strb = 4'b0000;
      exp_wd = 32'h0;
      if (op == SB) begin exp_strb = 4'(1 << o); exp_wd = (wd & 32'hFF) * 32'h0101_0101; end
      if (op == SH) begin exp_strb = 4'(3 << o); exp_wd = (wd & 32'hFFFF) * 32'h0001_0001; end
      if (op == SW) begin exp_strb = 4'hF; exp_wd = wd; end
      idx = a[9:2];
      exp_rdata = (!exp_err && !st) ? load_value(op, ref_mem[idx], o) : 32'h0;
      if (!exp_err && st)
         for (int i = 0; i < 4; i++)
            if (exp_strb[i]) ref_mem[idx][8*i +: 8] = exp_wd[8*i +: 8];

      @(negedge clk);
      check({tag, ".ready_idle"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; ALUControl = op; addr = a; wdata = wd; mem_ack = 1'b0;
      @(posedge clk);
      reqs = 0; got_cycle = 0; done = 0;
      stall_ok = 1; ready_ok = 1; stable_ok = 1;
      got_rdata = 32'h0; got_err = 1'b0;
      got_we = 1'b0; got_addr = 32'h0; got_strb = 4'h0; got_wd = 32'h0;
      for (int c = 1; c <= 400; c++) begin
         @(negedge clk);
         mem_ack = 1'b0;
         mem_rdata = $urandom;
         if (stall !== !rsp_valid) stall_ok = 0;
         if (req_ready !== 1'b0) ready_ok = 0;
         if (mem_req === 1'b1) begin
            if (reqs == 0) begin
               got_we = mem_we; got_addr = mem_addr; got_strb = mem_wstrb; got_wd = mem_wdata;
            end else if (mem_we !== got_we || mem_addr !== got_addr ||
                         mem_wstrb !== got_strb || mem_wdata !== got_wd) begin
               stable_ok = 0;
            end
            if (!no_ack && reqs == waits) begin
               eidx = mem_addr[9:2];
               mem_ack = 1'b1;
               mem_rdata = mem_env[eidx];
               if (mem_we)
                  for (int i = 0; i < 4; i++)
                     if (mem_wstrb[i]) mem_env[eidx][8*i +: 8] = mem_wdata[8*i +: 8];
            end
            reqs++;
         end
         if (rsp_valid === 1'b1) begin
            got_cycle = c; got_rdata = rsp_rdata; got_err = rsp_err;
            done = 1; req_valid = 1'b0; mem_ack = 1'b0;
            break;
         end
      end
      if (!done) begin
         req_valid = 1'b0; mem_ack = 1'b0;
      end
      check({tag, ".rsp_seen"}, 32'(done), 32'd1);
      check({tag, ".cycle"}, 32'(got_cycle), 32'(exp_cycle));
      check({tag, ".err"}, 32'(got_err), 32'(exp_err));
      check({tag, ".rdata"}, got_rdata, exp_rdata);
      check({tag, ".req_cycles"}, 32'(reqs), 32'(exp_reqs));
      check({tag, ".stall"}, 32'(stall_ok), 32'd1);
      check({tag, ".ready_busy"}, 32'(ready_ok), 32'd1);
      if (exp_reqs > 0) begin
         check({tag, ".mem_addr"}, got_addr, exp_addr);
         check({tag, ".mem_we"}, 32'(got_we), 32'(st));
         check({tag, ".mem_wstrb"}, 32'(got_strb), 32'(exp_strb));
         if (st) check({tag, ".mem_wdata"}, got_wd, exp_wd);
         check({tag, ".bus_stable"}, 32'(stable_ok), 32'd1);
      end
      @(posedge clk);
      #1;
      check({tag, ".rsp_pulse"}, 32'(rsp_valid), 32'd0);
      $display("op %s code=%h addr=%h wdata=%h waits=%0d noack=%0d -> cycle=%0d err=%0d rdata=%h",
               tag, op, a, wd, waits, no_ack, got_cycle, got_err, got_rdata);
   endtask

   logic [31:0] rd;
   logic        er;
   logic [5:0]  ops [0:9];
   int          rsp_seen_after_rst;
   int          req_seen_after_rst;

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem_env[i] = $urandom;
         ref_mem[i] = mem_env[i];
      end
      ops = '{LB, LBU, LH, LHU, LW, SB, SH, SW, 6'h3F, 6'h00};

      repeat (2) @(negedge clk);
      check("reset.req_ready", 32'(req_ready), 32'd1);
      check("reset.rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset.mem_req", 32'(mem_req), 32'd0);
      check("reset.mem_wstrb", 32'(mem_wstrb), 32'd0);
      check("reset.mem_addr", mem_addr, 32'd0);
      check("reset.rsp_rdata", rsp_rdata, 32'd0);
      rst_n = 1'b1;

      run_op("sb_1003", SB, 32'h1003, 32'h0000_00AB, 0, 0, rd, er);
      mem_env[0] = 32'h8001_1234;
      ref_mem[0] = 32'h8001_1234;
      run_op("lh_2002", LH, 32'h2002, 32'h0, 0, 0, rd, er);
      check("plan.lh", rd, 32'hFFFF_8001);
      run_op("lhu_2002", LHU, 32'h2002, 32'h0, 1, 0, rd, er);
      check("plan.lhu", rd, 32'h0000_8001);
      run_op("lb_2001", LB, 32'h2001, 32'h0, 2, 0, rd, er);
      check("plan.lb", rd, 32'h0000_0012);
      run_op("lw_3001", LW, 32'h3001, 32'h0, 0, 0, rd, er);
      check("plan.lw_mis", 32'(er), 32'd1);
      run_op("sh_3003", SH, 32'h3003, 32'h0, 0, 0, rd, er);
      check("plan.sh_mis", 32'(er), 32'd1);
      run_op("lw_timeout", LW, 32'h1010, 32'h0, 0, 1, rd, er);
      check("plan.timeout", 32'(er), 32'd1);
      run_op("lw_ack_last", LW, 32'h1010, 32'h0, TO - 1, 0, rd, er);
      check("plan.ack_last", 32'(er), 32'd0);

      // Reset during a 3-wait-state access.
      @(negedge clk);
      req_valid = 1'b1; ALUControl = LW; addr = 32'h1004; mem_ack = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("rst.mem_req_before", 32'(mem_req), 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      req_valid = 1'b0;
      #1;
      check("rst.mem_req_drop", 32'(mem_req), 32'd0);
      check("rst.req_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      mem_ack = 1'b1;
      mem_rdata = 32'hDEAD_BEEF;
      rsp_seen_after_rst = 0;
      req_seen_after_rst = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         mem_ack = 1'b0;
         if (rsp_valid === 1'b1) rsp_seen_after_rst++;
         if (mem_req === 1'b1) req_seen_after_rst++;
      end
      check("rst.no_rsp", 32'(rsp_seen_after_rst), 32'd0);
      check("rst.no_req", 32'(req_seen_after_rst), 32'd0);
      run_op("lw_after_rst", LW, 32'h1004, 32'h0, 1, 0, rd, er);

      run_op("b2b_sw", SW, 32'h1008, 32'hCAFE_F00D, 2, 0, rd, er);
      run_op("b2b_lw", LW, 32'h1008, 32'h0, 2, 0, rd, er);
      check("plan.b2b_data", rd, 32'hCAFE_F00D);

      for (int n = 0; n < 60; n++) begin
         logic [5:0]  op;
         logic [31:0] a;
         op = ops[$urandom_range(0, 9)];
         a = 32'h40 + 32'($urandom_range(0, 31));
         run_op($sformatf("rnd%0d", n), op, a, $urandom, $urandom_range(0, 5),
                ($urandom_range(0, 9) == 0), rd, er);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
